// File: rtl/hv_sync_generator.sv
// hv_sync_generator: VGA raster timing for the sale terminal display.
//
// Free-running horizontal/vertical position counters plus sync and blanking
// strobes. The position outputs are undelayed so the image locator and other
// consumers can register a pixel address from them; the sync/blank strobes go
// through a PIPE_DELAY-deep shift register so they reach the VGA DAC together
// with the pixel that the registered-address + ROM-read path produces.
//
// Ports:
//   CLK            system clock, one pixel per clock
//   RST            synchronous reset, active-high
//   CounterX       current horizontal position (undelayed)
//   CounterY       current vertical position (undelayed)
//   FrameStart     high while CounterX==0 and CounterY==0 (undelayed)
//   LineStart      high while CounterX==0 (undelayed)
//   FrameCount     completed-frame counter, wraps 255->0
//   HSync          horizontal sync, polarity H_POL, delayed by PIPE_DELAY
//   VSync          vertical sync, polarity V_POL, delayed by PIPE_DELAY
//   DisplayEnable  high in the active area, delayed by PIPE_DELAY
//   BLANK_N        same as DisplayEnable, for the DAC blank pin
//   SYNC_N         tied low (no sync-on-green)
module hv_sync_generator #(
  parameter int unsigned CNTR_WIDTH_H = 11,
  parameter int unsigned CNTR_WIDTH_V = 10,
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned H_FRONT      = 56,
  parameter int unsigned H_SYNC       = 120,
  parameter int unsigned H_BACK       = 64,
  parameter int unsigned V_VISIBLE    = 600,
  parameter int unsigned V_FRONT      = 37,
  parameter int unsigned V_SYNC       = 6,
  parameter int unsigned V_BACK       = 23,
  parameter bit          H_POL        = 1'b1,
  parameter bit          V_POL        = 1'b1,
  parameter int unsigned PIPE_DELAY   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic                    FrameStart,
  output logic                    LineStart,
  output logic [7:0]              FrameCount,
  output logic                    HSync,
  output logic                    VSync,
  output logic                    DisplayEnable,
  output logic                    BLANK_N,
  output logic                    SYNC_N
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CNTR_WIDTH_H-1:0] H_LAST = CNTR_WIDTH_H'(H_TOTAL - 1);
  localparam logic [CNTR_WIDTH_V-1:0] V_LAST = CNTR_WIDTH_V'(V_TOTAL - 1);

  // Elaboration-time sanity checks on the timing parameters.
  if (H_TOTAL > (32'd1 << CNTR_WIDTH_H)) begin : gen_h_total_chk
    $error("H_TOTAL does not fit in CNTR_WIDTH_H bits");
  end
  if (V_TOTAL > (32'd1 << CNTR_WIDTH_V)) begin : gen_v_total_chk
    $error("V_TOTAL does not fit in CNTR_WIDTH_V bits");
  end
  if ((PIPE_DELAY < 1) || (PIPE_DELAY > 8)) begin : gen_pipe_chk
    $error("PIPE_DELAY must be in 1..8");
  end

  logic [CNTR_WIDTH_H-1:0] cnt_x_q, cnt_x_d;
  logic [CNTR_WIDTH_V-1:0] cnt_y_q, cnt_y_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic [PIPE_DELAY-1:0]   hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0]   vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0]   de_pipe_q, de_pipe_d;

  logic x_last, y_last;
  logic hs_raw, vs_raw, de_raw;
  logic hs_lvl, vs_lvl;

  // Counter next-state.
  always_comb begin
    x_last      = (cnt_x_q == H_LAST);
    y_last      = (cnt_y_q == V_LAST);
    cnt_x_d     = cnt_x_q + CNTR_WIDTH_H'(1);
    cnt_y_d     = cnt_y_q;
    frame_cnt_d = frame_cnt_q;
    if (x_last) begin
      cnt_x_d = '0;
      if (y_last) begin
        cnt_y_d     = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        cnt_y_d = cnt_y_q + CNTR_WIDTH_V'(1);
      end
    end
  end

  // Raw strobes. Compared at 32 bits so an end bound equal to 2^width
  // (zero back porch with an exactly-full counter) cannot overflow.
  always_comb begin
    hs_raw = (32'(cnt_x_q) >= HS_START) && (32'(cnt_x_q) < HS_END);
    vs_raw = (32'(cnt_y_q) >= VS_START) && (32'(cnt_y_q) < VS_END);
    de_raw = (32'(cnt_x_q) < H_VISIBLE) && (32'(cnt_y_q) < V_VISIBLE);
    // Polarity is applied ahead of the delay line so reset-loaded stages
    // already hold the inactive level.
    hs_lvl = hs_raw ^ ~H_POL;
    vs_lvl = vs_raw ^ ~V_POL;
  end

  // Delay lines: stage 0 takes the raw value, the last stage drives the pin.
  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    de_pipe_d    = de_pipe_q;
    hs_pipe_d[0] = hs_lvl;
    vs_pipe_d[0] = vs_lvl;
    de_pipe_d[0] = de_raw;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      de_pipe_d[i] = de_pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      frame_cnt_q <= '0;
      hs_pipe_q   <= {PIPE_DELAY{~H_POL}};
      vs_pipe_q   <= {PIPE_DELAY{~V_POL}};
      de_pipe_q   <= '0;
    end else begin
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      frame_cnt_q <= frame_cnt_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      de_pipe_q   <= de_pipe_d;
    end
  end

  assign CounterX      = cnt_x_q;
  assign CounterY      = cnt_y_q;
  assign FrameStart    = (cnt_x_q == '0) && (cnt_y_q == '0);
  assign LineStart     = (cnt_x_q == '0);
  assign FrameCount    = frame_cnt_q;
  assign HSync         = hs_pipe_q[PIPE_DELAY-1];
  assign VSync         = vs_pipe_q[PIPE_DELAY-1];
  assign DisplayEnable = de_pipe_q[PIPE_DELAY-1];
  assign BLANK_N       = de_pipe_q[PIPE_DELAY-1];
  assign SYNC_N        = 1'b0;

endmodule

// File: tb/tb_hv_sync_generator.sv
// Directed bench for hv_sync_generator.
// Instance A: default 800x600@72 timing, PIPE_DELAY=2, active-high syncs.
// Instance B: shrunken raster (16x8 clocks per frame) to cover frame and
//             FrameCount wrap timing within a short run.
// Instance C: default timing, PIPE_DELAY=1, active-low syncs.
module tb_hv_sync_generator;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        a_rst, b_rst, c_rst;
  logic [10:0] a_x;   logic [9:0] a_y;
  logic [3:0]  b_x;   logic [2:0] b_y;
  logic [10:0] c_x;   logic [9:0] c_y;
  logic        a_fs, a_ls, a_hs, a_vs, a_de, a_bn, a_sn;
  logic        b_fs, b_ls, b_hs, b_vs, b_de, b_bn, b_sn;
  logic        c_fs, c_ls, c_hs, c_vs, c_de, c_bn, c_sn;
  logic [7:0]  a_fc, b_fc, c_fc;

  hv_sync_generator u_a (
    .CLK(CLK), .RST(a_rst), .CounterX(a_x), .CounterY(a_y), .FrameStart(a_fs),
    .LineStart(a_ls), .FrameCount(a_fc), .HSync(a_hs), .VSync(a_vs),
    .DisplayEnable(a_de), .BLANK_N(a_bn), .SYNC_N(a_sn)
  );

  hv_sync_generator #(
    .CNTR_WIDTH_H(4), .CNTR_WIDTH_V(3),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_b (
    .CLK(CLK), .RST(b_rst), .CounterX(b_x), .CounterY(b_y), .FrameStart(b_fs),
    .LineStart(b_ls), .FrameCount(b_fc), .HSync(b_hs), .VSync(b_vs),
    .DisplayEnable(b_de), .BLANK_N(b_bn), .SYNC_N(b_sn)
  );

  hv_sync_generator #(
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(1)
  ) u_c (
    .CLK(CLK), .RST(c_rst), .CounterX(c_x), .CounterY(c_y), .FrameStart(c_fs),
    .LineStart(c_ls), .FrameCount(c_fc), .HSync(c_hs), .VSync(c_vs),
    .DisplayEnable(c_de), .BLANK_N(c_bn), .SYNC_N(c_sn)
  );

  // Each step lands on a falling edge, i.e. mid-cycle after a rising edge.
  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if ({a_fs, a_ls, a_hs, a_de, a_bn} !== 5'b11000) begin
      bad++;
      $display("FAIL a_in_reset fs/ls/hs/de/bn got=%b want=11000", {a_fs, a_ls, a_hs, a_de, a_bn});
    end
    @(negedge CLK);
    a_rst = 1'b0;
    cyc   = 0;
    total++;
    if (a_x !== 11'd0 || a_y !== 10'd0 || a_fc !== 8'd0) begin
      bad++;
      $display("FAIL a_cycle0_counters got x=%0d y=%0d fc=%0d want 0 0 0", a_x, a_y, a_fc);
    end
    total++;
    if ({a_fs, a_ls, a_hs, a_vs, a_de, a_bn, a_sn} !== 7'b1100000) begin
      bad++;
      $display("FAIL a_cycle0_strobes got=%b want=1100000",
               {a_fs, a_ls, a_hs, a_vs, a_de, a_bn, a_sn});
    end
  endtask

  task automatic test_active_edge();
    logic exp_de;
    while (cyc < 805) begin
      step();
      exp_de = (cyc >= 2) && (cyc <= 801);
      total++;
      if (a_de !== exp_de || a_bn !== exp_de) begin
        bad++;
        $display("FAIL active_edge cyc=%0d got de=%b bn=%b want=%b", cyc, a_de, a_bn, exp_de);
      end
      total++;
      if (a_x !== 11'(cyc) || a_y !== 10'd0) begin
        bad++;
        $display("FAIL active_x cyc=%0d got x=%0d y=%0d want x=%0d y=0", cyc, a_x, a_y, cyc);
      end
    end
  endtask

  task automatic test_hsync();
    logic exp_hs;
    int   ph;
    while (cyc < 3100) begin
      step();
      ph     = (cyc - 2) % 1040;
      exp_hs = (ph >= 856) && (ph < 976);
      total++;
      if (a_hs !== exp_hs) begin
        bad++;
        $display("FAIL hsync cyc=%0d got=%b want=%b", cyc, a_hs, exp_hs);
      end
      total++;
      if (a_x !== 11'(cyc % 1040) || a_y !== 10'(cyc / 1040)) begin
        bad++;
        $display("FAIL hsync_pos cyc=%0d got x=%0d y=%0d want x=%0d y=%0d",
                 cyc, a_x, a_y, cyc % 1040, cyc / 1040);
      end
      if (cyc == 1040 || cyc == 2080) begin
        total++;
        if (a_ls !== 1'b1 || a_fs !== 1'b0 || a_vs !== 1'b0) begin
          bad++;
          $display("FAIL line_start cyc=%0d got ls=%b fs=%b vs=%b want 1 0 0",
                   cyc, a_ls, a_fs, a_vs);
        end
      end
    end
  endtask

  task automatic test_mid_reset_a();
    step_to(3 * 1040 + 900);
    total++;
    if (a_hs !== 1'b1 || a_y !== 10'd3 || a_x !== 11'd900) begin
      bad++;
      $display("FAIL a_pre_reset got hs=%b y=%0d x=%0d want 1 3 900", a_hs, a_y, a_x);
    end
    a_rst = 1'b1;
    @(negedge CLK);
    a_rst = 1'b0;
    cyc   = 0;
    total++;
    if (a_x !== 11'd0 || a_y !== 10'd0 || a_hs !== 1'b0 || a_de !== 1'b0 || a_fc !== 8'd0) begin
      bad++;
      $display("FAIL a_mid_reset c0 got x=%0d y=%0d hs=%b de=%b fc=%0d want 0 0 0 0 0",
               a_x, a_y, a_hs, a_de, a_fc);
    end
    step();
    total++;
    if (a_hs !== 1'b0 || a_de !== 1'b0) begin
      bad++;
      $display("FAIL a_mid_reset c1 got hs=%b de=%b want 0 0", a_hs, a_de);
    end
    step();
    total++;
    if (a_hs !== 1'b0 || a_de !== 1'b1 || a_x !== 11'd2) begin
      bad++;
      $display("FAIL a_mid_reset c2 got hs=%b de=%b x=%0d want 0 1 2", a_hs, a_de, a_x);
    end
  endtask

  task automatic test_frame();
    int   vs_high = 0;
    int   p;
    logic exp_vs, exp_de, exp_hs;
    b_rst = 1'b1;
    repeat (3) @(negedge CLK);
    b_rst = 1'b0;
    cyc   = 0;
    while (cyc < 256) begin
      p      = (cyc - 2) % 128;
      exp_vs = (cyc >= 2) && (p / 16 >= 5) && (p / 16 <= 6);
      exp_de = (cyc >= 2) && (p % 16 < 8) && (p / 16 < 4);
      exp_hs = (cyc >= 2) && (p % 16 >= 10) && (p % 16 <= 12);
      if (cyc < 128 && b_vs === 1'b1) vs_high++;
      total++;
      if (b_vs !== exp_vs || b_de !== exp_de || b_bn !== exp_de || b_hs !== exp_hs) begin
        bad++;
        $display("FAIL b_strobes cyc=%0d got vs=%b de=%b bn=%b hs=%b want vs=%b de=%b hs=%b",
                 cyc, b_vs, b_de, b_bn, b_hs, exp_vs, exp_de, exp_hs);
      end
      total++;
      if (b_x !== 4'(cyc % 16) || b_y !== 3'((cyc / 16) % 8) || b_fc !== 8'(cyc / 128)) begin
        bad++;
        $display("FAIL b_counters cyc=%0d got x=%0d y=%0d fc=%0d want x=%0d y=%0d fc=%0d",
                 cyc, b_x, b_y, b_fc, cyc % 16, (cyc / 16) % 8, cyc / 128);
      end
      total++;
      if (b_fs !== (cyc % 128 == 0) || b_ls !== (cyc % 16 == 0) || b_sn !== 1'b0) begin
        bad++;
        $display("FAIL b_starts cyc=%0d got fs=%b ls=%b sn=%b", cyc, b_fs, b_ls, b_sn);
      end
      step();
    end
    total++;
    if (vs_high != 32) begin
      bad++;
      $display("FAIL b_vsync_width got=%0d want=32", vs_high);
    end
    step_to(256 * 128 - 1);
    total++;
    if (b_fc !== 8'd255 || b_x !== 4'd15 || b_y !== 3'd7) begin
      bad++;
      $display("FAIL b_pre_wrap got fc=%0d x=%0d y=%0d want 255 15 7", b_fc, b_x, b_y);
    end
    step();
    total++;
    if (b_fc !== 8'd0 || b_x !== 4'd0 || b_y !== 3'd0 || b_fs !== 1'b1) begin
      bad++;
      $display("FAIL b_fc_wrap got fc=%0d x=%0d y=%0d fs=%b want 0 0 0 1", b_fc, b_x, b_y, b_fs);
    end
  endtask

  task automatic test_mid_reset_b();
    step_to(256 * 128 + 128 + 37);
    total++;
    if (b_fc !== 8'd1 || b_x !== 4'd5 || b_y !== 3'd2 || b_de !== 1'b1) begin
      bad++;
      $display("FAIL b_pre_reset got fc=%0d x=%0d y=%0d de=%b want 1 5 2 1", b_fc, b_x, b_y, b_de);
    end
    b_rst = 1'b1;
    @(negedge CLK);
    b_rst = 1'b0;
    cyc   = 0;
    total++;
    if (b_fc !== 8'd0 || b_x !== 4'd0 || b_y !== 3'd0 || b_de !== 1'b0 || b_vs !== 1'b0) begin
      bad++;
      $display("FAIL b_mid_reset c0 got fc=%0d x=%0d y=%0d de=%b vs=%b want 0 0 0 0 0",
               b_fc, b_x, b_y, b_de, b_vs);
    end
    step();
    total++;
    if (b_de !== 1'b0) begin
      bad++;
      $display("FAIL b_mid_reset c1 got de=%b want 0", b_de);
    end
    step();
    total++;
    if (b_de !== 1'b1) begin
      bad++;
      $display("FAIL b_mid_reset c2 got de=%b want 1", b_de);
    end
  endtask

  task automatic test_param_sweep();
    total++;
    if (c_hs !== 1'b1 || c_vs !== 1'b1 || c_de !== 1'b0) begin
      bad++;
      $display("FAIL c_in_reset got hs=%b vs=%b de=%b want 1 1 0", c_hs, c_vs, c_de);
    end
    c_rst = 1'b0;
    cyc   = 0;
    total++;
    if (c_hs !== 1'b1 || c_vs !== 1'b1 || c_de !== 1'b0 || c_bn !== 1'b0 || c_sn !== 1'b0) begin
      bad++;
      $display("FAIL c_cycle0 got hs=%b vs=%b de=%b bn=%b sn=%b want 1 1 0 0 0",
               c_hs, c_vs, c_de, c_bn, c_sn);
    end
    total++;
    if (c_x !== 11'd0 || c_y !== 10'd0 || c_fc !== 8'd0 || c_fs !== 1'b1 || c_ls !== 1'b1) begin
      bad++;
      $display("FAIL c_cycle0_pos got x=%0d y=%0d fc=%0d fs=%b ls=%b", c_x, c_y, c_fc, c_fs, c_ls);
    end
    step();
    total++;
    if (c_de !== 1'b1) begin
      bad++;
      $display("FAIL c_de_c1 got=%b want=1", c_de);
    end
    step_to(856);
    total++;
    if (c_hs !== 1'b1) begin
      bad++;
      $display("FAIL c_hs_856 got=%b want=1", c_hs);
    end
    step();
    total++;
    if (c_hs !== 1'b0) begin
      bad++;
      $display("FAIL c_hs_857 got=%b want=0", c_hs);
    end
    step_to(976);
    total++;
    if (c_hs !== 1'b0) begin
      bad++;
      $display("FAIL c_hs_976 got=%b want=0", c_hs);
    end
    step();
    total++;
    if (c_hs !== 1'b1 || c_vs !== 1'b1) begin
      bad++;
      $display("FAIL c_hs_977 got hs=%b vs=%b want 1 1", c_hs, c_vs);
    end
  endtask

  initial begin
    a_rst = 1'b1;
    b_rst = 1'b1;
    c_rst = 1'b1;
    test_reset();
    test_active_edge();
    test_hsync();
    test_mid_reset_a();
    test_frame();
    test_mid_reset_b();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
